// File: rtl/cgra_ctrl_pkg.sv
// cgra_ctrl_pkg: shared state encoding and latency defaults for the kernel sequencer
package cgra_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int FILL_LAT_DEF = 2;
  localparam int DRAIN_LAT_DEF = 4;
  function automatic int drain_w(input int lat);
    return lat < 1 ? 1 : $clog2(lat + 1);
  endfunction
endpackage

// File: rtl/cgra_kernel_sequencer_if.sv
// cgra_kernel_sequencer_if: software start/done handshake and instruction-fetch schedule
interface cgra_kernel_sequencer_if #(parameter int ADDR_W = 8, parameter int ITER_W = 16);
  logic Computation_Start;
  logic [ADDR_W-1:0] Kernel_Len;
  logic [ITER_W-1:0] Iter_Num;
  logic Inst_Rd_En;
  logic [ADDR_W-1:0] Inst_Addr;
  logic [ITER_W-1:0] Iter_Cnt;
  logic PE_Array_Busy;
  logic Computation_Done;
  modport master(output Computation_Start, Kernel_Len, Iter_Num,
                 input Inst_Rd_En, Inst_Addr, Iter_Cnt, PE_Array_Busy, Computation_Done);
  modport slave(input Computation_Start, Kernel_Len, Iter_Num,
                output Inst_Rd_En, Inst_Addr, Iter_Cnt, PE_Array_Busy, Computation_Done);
endinterface

// File: rtl/cgra_mod_counter.sv
// cgra_mod_counter: modulo-n counter with clear and enable; wrap flags the terminal count n-1
module cgra_mod_counter #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] n,
  output logic [W-1:0] cnt,
  output logic         wrap
);
  assign wrap = cnt == n - W'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= wrap ? '0 : cnt + W'(1);
endmodule

// File: rtl/cgra_kernel_sequencer.sv
// cgra_kernel_sequencer: runs a kernel for a latched length and iteration count,
// drains the PE pipeline, then holds Done until software drops Start.
module cgra_kernel_sequencer
  import cgra_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int ITER_W    = 16,
  parameter int FILL_LAT  = FILL_LAT_DEF,
  parameter int DRAIN_LAT = DRAIN_LAT_DEF
) (
  input logic Clk,
  input logic Resetn,
  cgra_kernel_sequencer_if.slave bus
);
  localparam int DW = drain_w(FILL_LAT + DRAIN_LAT);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(FILL_LAT + DRAIN_LAT);
  state_t state, state_nx;
  logic [ADDR_W-1:0] len_q;
  logic [ITER_W-1:0] iter_q;
  logic [DW-1:0] drain_q;
  logic run, clr, last, addr_end, iter_end;
  assign run = state == RUN;
  assign last = run && addr_end && iter_end;
  assign clr = state == DONE && !bus.Computation_Start;
  // the final address is held through DRAIN and DONE rather than wrapping
  cgra_mod_counter #(.W(ADDR_W)) u_addr (
    .clk(Clk), .rst_n(Resetn), .clr(clr), .en(run && !last), .n(len_q),
    .cnt(bus.Inst_Addr), .wrap(addr_end)
  );
  cgra_mod_counter #(.W(ITER_W)) u_iter (
    .clk(Clk), .rst_n(Resetn), .clr(clr), .en(run && addr_end && !last), .n(iter_q),
    .cnt(bus.Iter_Cnt), .wrap(iter_end)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.Computation_Start)
                 state_nx = (bus.Kernel_Len == '0 || bus.Iter_Num == '0) ? DONE : RUN;
      RUN:     if (last) state_nx = DRAIN;
      DRAIN:   if (drain_q <= DW'(1)) state_nx = DONE;
      default: if (!bus.Computation_Start) state_nx = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Resetn)
    if (!Resetn) begin
      state <= IDLE;
      len_q <= '0;
      iter_q <= '0;
      drain_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.Computation_Start) begin
        len_q <= bus.Kernel_Len;
        iter_q <= bus.Iter_Num;
      end
      drain_q <= state == DRAIN ? drain_q - DW'(1) : DRAIN_INIT;
    end
  assign bus.Inst_Rd_En = run;
  assign bus.PE_Array_Busy = run || state == DRAIN;
  assign bus.Computation_Done = state == DONE;
endmodule

// File: tb/tb_cgra_kernel_sequencer.sv
// tb_cgra_kernel_sequencer: directed scenarios plus randomized runs against a cycle-index model
module tb_cgra_kernel_sequencer;
  localparam int FL = 2;
  localparam int DL = 4;
  logic Clk = 0;
  logic Resetn;
  int checks = 0;
  int errors = 0;
  bit armed = 0;
  always #5 Clk = ~Clk;

  cgra_kernel_sequencer_if #(.ADDR_W(8), .ITER_W(16)) bus ();
  cgra_kernel_sequencer #(.ADDR_W(8), .ITER_W(16), .FILL_LAT(FL), .DRAIN_LAT(DL)) dut (
    .Clk(Clk), .Resetn(Resetn), .bus(bus)
  );

  // model: a run is described by its length, count and the number of edges since it started
  bit m_act = 0, m_done = 0;
  longint m_k = 0, m_L = 0, m_N = 0;
  always @(posedge Clk or negedge Resetn)
    if (!Resetn) begin
      m_act = 0; m_done = 0; m_k = 0; m_L = 0; m_N = 0;
    end else if (m_act) begin
      m_k++;
      if (m_k == m_L * m_N + FL + DL) begin m_act = 0; m_done = 1; end
    end else if (m_done) begin
      if (!bus.Computation_Start) m_done = 0;
    end else if (bus.Computation_Start) begin
      m_L = bus.Kernel_Len; m_N = bus.Iter_Num; m_k = 0;
      if (m_L * m_N == 0) m_done = 1; else m_act = 1;
    end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  longint e_addr, e_iter, ln;
  bit e_rd, e_busy, e_done;
  always @(negedge Clk) if (armed) begin
    ln = m_L * m_N;
    e_rd = 0; e_busy = 0; e_done = 0; e_addr = 0; e_iter = 0;
    if (m_act && m_k < ln) begin
      e_rd = 1; e_busy = 1; e_addr = m_k % m_L; e_iter = m_k / m_L;
    end else if (m_act) begin
      e_busy = 1; e_addr = m_L - 1; e_iter = m_N - 1;
    end else if (m_done) begin
      e_done = 1;
      if (ln != 0) begin e_addr = m_L - 1; e_iter = m_N - 1; end
    end
    chk("m_rd_en", bus.Inst_Rd_En, e_rd);
    chk("m_busy", bus.PE_Array_Busy, e_busy);
    chk("m_done", bus.Computation_Done, e_done);
    chk("m_addr", bus.Inst_Addr, e_addr);
    chk("m_iter", bus.Iter_Cnt, e_iter);
  end

  task automatic finish_run();
    int n = 0;
    while (bus.Computation_Done !== 1'b1 && n < 3000) begin @(negedge Clk); n++; end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL done_timeout: Computation_Done=%b after %0d cycles, expected 1", bus.Computation_Done, n);
    end
    bus.Computation_Start = 0;
    repeat (2) @(negedge Clk);
  endtask

  int na[6] = '{0, 1, 2, 0, 1, 2};
  int ni[6] = '{0, 0, 0, 1, 1, 1};

  initial begin
    Resetn = 1;
    bus.Computation_Start = 0; bus.Kernel_Len = 0; bus.Iter_Num = 0;
    #1 Resetn = 0;
    repeat (2) @(negedge Clk);
    chk("rst_busy", bus.PE_Array_Busy, 0);
    chk("rst_done", bus.Computation_Done, 0);
    chk("rst_addr", bus.Inst_Addr, 0);
    Resetn = 1; armed = 1;
    @(negedge Clk);
    // nominal L=3 N=2
    bus.Kernel_Len = 3; bus.Iter_Num = 2; bus.Computation_Start = 1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge Clk);
      if (c <= 6) begin
        chk("nom_addr", bus.Inst_Addr, na[c-1]);
        chk("nom_iter", bus.Iter_Cnt, ni[c-1]);
      end
      if (c == 12) chk("nom_busy12", bus.PE_Array_Busy, 1);
      if (c == 12) chk("nom_done12", bus.Computation_Done, 0);
      if (c == 13) chk("nom_done13", bus.Computation_Done, 1);
      if (c == 20) begin chk("nom_done20", bus.Computation_Done, 1); bus.Computation_Start = 0; end
      if (c == 21) chk("nom_done21", bus.Computation_Done, 0);
    end
    // zero length
    bus.Kernel_Len = 0; bus.Iter_Num = 5; bus.Computation_Start = 1;
    @(negedge Clk);
    chk("zero_done1", bus.Computation_Done, 1);
    chk("zero_busy1", bus.PE_Array_Busy, 0);
    chk("zero_rd1", bus.Inst_Rd_En, 0);
    bus.Computation_Start = 0;
    repeat (2) @(negedge Clk);
    // early Start release: L=4 N=1
    bus.Kernel_Len = 4; bus.Iter_Num = 1; bus.Computation_Start = 1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge Clk);
      if (c == 2) bus.Computation_Start = 0;
      if (c == 10) chk("early_busy10", bus.PE_Array_Busy, 1);
      if (c == 11) chk("early_done11", bus.Computation_Done, 1);
      if (c == 12) chk("early_done12", bus.Computation_Done, 0);
    end
    // latched configuration
    bus.Kernel_Len = 3; bus.Iter_Num = 2; bus.Computation_Start = 1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clk);
      if (c == 2) bus.Kernel_Len = 7;
      if (c == 3) chk("latch_addr3", bus.Inst_Addr, 2);
      if (c == 4) chk("latch_addr4", bus.Inst_Addr, 0);
    end
    finish_run();
    bus.Iter_Num = 1; bus.Computation_Start = 1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge Clk);
      if (c == 7) chk("latch_new_addr7", bus.Inst_Addr, 6);
      if (c == 8) chk("latch_new_rd8", bus.Inst_Rd_En, 0);
    end
    finish_run();
    // reset mid-run
    bus.Kernel_Len = 5; bus.Iter_Num = 3; bus.Computation_Start = 1;
    repeat (4) @(negedge Clk);
    #2 Resetn = 0;
    #1;
    chk("arst_rd", bus.Inst_Rd_En, 0);
    chk("arst_busy", bus.PE_Array_Busy, 0);
    chk("arst_addr", bus.Inst_Addr, 0);
    chk("arst_iter", bus.Iter_Cnt, 0);
    @(negedge Clk);
    Resetn = 1;
    @(negedge Clk);
    chk("arst_fresh_addr", bus.Inst_Addr, 0);
    chk("arst_fresh_rd", bus.Inst_Rd_En, 1);
    finish_run();
    // maximum values, aborted by reset after the first address wraps
    bus.Kernel_Len = 255; bus.Iter_Num = 16'hFFFF; bus.Computation_Start = 1;
    for (int c = 1; c <= 600; c++) begin
      @(negedge Clk);
      if (c == 255) chk("max_addr255", bus.Inst_Addr, 254);
      if (c == 256) chk("max_addr256", bus.Inst_Addr, 0);
      if (c == 256) chk("max_iter256", bus.Iter_Cnt, 1);
    end
    bus.Computation_Start = 0;
    #2 Resetn = 0;
    @(negedge Clk);
    Resetn = 1;
    @(negedge Clk);
    // randomized runs
    for (int r = 0; r < 24; r++) begin
      bus.Kernel_Len = 8'($urandom_range(0, 5));
      bus.Iter_Num = 16'($urandom_range(0, 4));
      bus.Computation_Start = 1;
      for (int c = 0; c < 60; c++) begin
        @(negedge Clk);
        bus.Computation_Start = $urandom_range(0, 3) != 0;
        if ($urandom_range(0, 7) == 0) bus.Kernel_Len = 8'($urandom_range(0, 7));
        if ($urandom_range(0, 7) == 0) bus.Iter_Num = 16'($urandom_range(0, 3));
        if (r % 7 == 3 && c == 9) begin #2 Resetn = 0; #4 Resetn = 1; end
      end
      bus.Computation_Start = 0;
      repeat (3) @(negedge Clk);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
